// File: rtl/exc_sequencer_if.sv
// Request/strobe bundle between the pipeline and the exception sequencer.
// The sequencer side uses the slave modport; the pipeline/control side uses master.
interface exc_sequencer_if #(
    parameter int IRQ_NUM = 4
);
    logic               ill_req;
    logic               trap_req;
    logic               rfi_req;
    logic [IRQ_NUM-1:0] irq;
    logic               psr_ie;
    logic               pipe_idle;
    logic               flush;
    logic               ill_inst;
    logic               trap;
    logic               irq_take;
    logic               rfi;
    logic [3:0]         cause;
    logic [IRQ_NUM-1:0] pending;
    logic               busy;
    logic [1:0]         state_dbg;

    modport master (
        output ill_req, trap_req, rfi_req, irq, psr_ie, pipe_idle,
        input  flush, ill_inst, trap, irq_take, rfi, cause, pending, busy, state_dbg
    );

    modport slave (
        input  ill_req, trap_req, rfi_req, irq, psr_ie, pipe_idle,
        output flush, ill_inst, trap, irq_take, rfi, cause, pending, busy, state_dbg
    );
endinterface

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: prioritise one event, drain the pipe, then
// issue a single control-register strobe followed by one settle cycle.
module exc_sequencer #(
    parameter int IRQ_NUM   = 4,
    parameter int DRAIN_MAX = 15
) (
    input  logic           clk,
    input  logic           rst,
    exc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FIRE, S_SETTLE} state_t;
    typedef enum logic [1:0] {EV_ILL, EV_TRAP, EV_IRQ, EV_RFI} event_t;

    state_t             r_state;
    event_t             r_event;
    logic [3:0]         r_cnt;
    logic [3:0]         r_cause;
    logic [2:0]         r_irq_idx;
    logic [IRQ_NUM-1:0] r_irq_prev;
    logic [IRQ_NUM-1:0] r_pending;
    logic               r_busy;
    logic               r_ill;
    logic               r_trap;
    logic               r_take;
    logic               r_rfi;

    logic               w_sel_valid;
    event_t             w_sel_event;
    logic [3:0]         w_sel_cause;
    logic [2:0]         w_irq_idx;
    logic               w_irq_any;
    logic [IRQ_NUM-1:0] w_rise;
    logic [IRQ_NUM-1:0] w_clr;

    // Lowest pending index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        w_irq_idx = '0;
        w_irq_any = 1'b0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_irq_idx = 3'(i);
                w_irq_any = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b1;
        w_sel_event = EV_ILL;
        w_sel_cause = 4'h3;
        if (bus.ill_req) begin
            w_sel_event = EV_ILL;
            w_sel_cause = 4'h3;
        end else if (bus.trap_req) begin
            w_sel_event = EV_TRAP;
            w_sel_cause = 4'h5;
        end else if (bus.psr_ie && w_irq_any) begin
            w_sel_event = EV_IRQ;
            w_sel_cause = 4'h8 | {1'b0, w_irq_idx};
        end else if (bus.rfi_req) begin
            w_sel_event = EV_RFI;
            w_sel_cause = 4'h1;
        end else begin
            w_sel_valid = 1'b0;
        end
        if (r_state != S_IDLE) w_sel_valid = 1'b0;
    end

    assign w_rise = bus.irq & ~r_irq_prev;
    assign w_clr  = r_take ? (IRQ_NUM'(1) << r_irq_idx) : '0;

    // A new rising edge on the bit being taken survives the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
        end else begin
            r_irq_prev <= bus.irq;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_event   <= EV_ILL;
            r_cnt     <= '0;
            r_cause   <= '0;
            r_irq_idx <= '0;
            r_busy    <= 1'b0;
            r_ill     <= 1'b0;
            r_trap    <= 1'b0;
            r_take    <= 1'b0;
            r_rfi     <= 1'b0;
        end else begin
            r_ill  <= 1'b0;
            r_trap <= 1'b0;
            r_take <= 1'b0;
            r_rfi  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_valid) begin
                        r_state   <= S_DRAIN;
                        r_busy    <= 1'b1;
                        r_event   <= w_sel_event;
                        r_cause   <= w_sel_cause;
                        r_irq_idx <= w_irq_idx;
                        r_cnt     <= '0;
                    end
                end
                S_DRAIN: begin
                    if (bus.pipe_idle || (r_cnt == 4'(DRAIN_MAX))) begin
                        r_state <= S_FIRE;
                        case (r_event)
                            EV_ILL:  r_ill  <= 1'b1;
                            EV_TRAP: r_trap <= 1'b1;
                            EV_IRQ:  r_take <= 1'b1;
                            EV_RFI:  r_rfi  <= 1'b1;
                            default: r_ill  <= 1'b0;
                        endcase
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_FIRE: begin
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // flush leads busy by one cycle so younger instructions die in the selecting cycle.
    assign bus.flush     = r_busy | w_sel_valid;
    assign bus.busy      = r_busy;
    assign bus.ill_inst  = r_ill;
    assign bus.trap      = r_trap;
    assign bus.irq_take  = r_take;
    assign bus.rfi       = r_rfi;
    assign bus.cause     = r_cause;
    assign bus.pending   = r_pending;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: a per-cycle vector table plus hand-written
// drain-timeout and asynchronous-reset sequences.
module tb_exc_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    exc_sequencer_if #(.IRQ_NUM(4)) bus_if ();

    exc_sequencer #(.IRQ_NUM(4), .DRAIN_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ill;
        logic       trap;
        logic       rfi;
        logic [3:0] irq;
        logic       ie;
        logic       idle;
        logic       e_flush;
        logic       e_ill;
        logic       e_trap;
        logic       e_take;
        logic       e_rfi;
        logic       e_busy;
        logic [3:0] e_cause;
        logic [3:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int ill, input int trap, input int rfi, input int irq,
                                input int ie, input int idle, input int fl, input int s_ill,
                                input int s_trap, input int s_take, input int s_rfi,
                                input int busy, input int cause, input int pend);
        vec_t v;
        v.ill     = ill[0];
        v.trap    = trap[0];
        v.rfi     = rfi[0];
        v.irq     = irq[3:0];
        v.ie      = ie[0];
        v.idle    = idle[0];
        v.e_flush = fl[0];
        v.e_ill   = s_ill[0];
        v.e_trap  = s_trap[0];
        v.e_take  = s_take[0];
        v.e_rfi   = s_rfi[0];
        v.e_busy  = busy[0];
        v.e_cause = cause[3:0];
        v.e_pend  = pend[3:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Registered outputs are settled 1 unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ill, input logic trap, input logic rfi,
                         input logic [3:0] irq, input logic ie, input logic idle);
        bus_if.ill_req   = ill;
        bus_if.trap_req  = trap;
        bus_if.rfi_req   = rfi;
        bus_if.irq       = irq;
        bus_if.psr_ie    = ie;
        bus_if.pipe_idle = idle;
    endtask

    // Strobes must be one-hot-or-zero and never in back-to-back cycles.
    logic prev_strobe;
    always @(negedge clk) begin
        logic [3:0] s;
        s = {bus_if.ill_inst, bus_if.trap, bus_if.irq_take, bus_if.rfi};
        if (!rst) begin
            total++;
            if ($countones(s) > 1 || (prev_strobe && (s != 4'b0))) begin
                bad++;
                $display("FAIL strobe_excl: strobes=%b prev=%b", s, prev_strobe);
            end
            prev_strobe = (s != 4'b0);
        end else begin
            prev_strobe = 1'b0;
        end
    end

    initial begin
        int first_idx;
        int n_ill, n_trap, n_take, n_rfi;
        logic [3:0] cause_at;

        total       = 0;
        bad         = 0;
        prev_strobe = 1'b0;
        rst         = 1'b1;
        drive(0, 0, 0, 4'h0, 0, 0);

        // Reset state
        step();
        step();
        check("rst_flush", 32'(bus_if.flush), 0);
        check("rst_busy", 32'(bus_if.busy), 0);
        check("rst_strobes", 32'({bus_if.ill_inst, bus_if.trap, bus_if.irq_take, bus_if.rfi}), 0);
        check("rst_cause", 32'(bus_if.cause), 0);
        check("rst_pending", 32'(bus_if.pending), 0);
        #1 rst = 1'b0;

        // ill+trap, irq 0110, irq0 with late psr_ie, rfi vs pending irq3, plain rfi
        vecs.push_back(mk(1,1,0,0,0,1, 1,0,0,0,0,0, 0,0));
        vecs.push_back(mk(1,0,0,0,0,1, 1,0,0,0,0,1, 3,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,1,0,0,0,1, 3,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0,1, 3,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 3,0));
        vecs.push_back(mk(0,0,0,6,1,1, 0,0,0,0,0,0, 3,0));
        vecs.push_back(mk(0,0,0,6,1,1, 1,0,0,0,0,0, 3,6));
        vecs.push_back(mk(0,0,0,6,1,1, 1,0,0,0,0,1, 9,6));
        vecs.push_back(mk(0,0,0,6,1,1, 1,0,0,1,0,1, 9,6));
        vecs.push_back(mk(0,0,0,6,1,1, 1,0,0,0,0,1, 9,4));
        vecs.push_back(mk(0,0,0,6,1,1, 1,0,0,0,0,0, 9,4));
        vecs.push_back(mk(0,0,0,6,1,1, 1,0,0,0,0,1, 10,4));
        vecs.push_back(mk(0,0,0,6,1,1, 1,0,0,1,0,1, 10,4));
        vecs.push_back(mk(0,0,0,6,1,1, 1,0,0,0,0,1, 10,0));
        vecs.push_back(mk(0,0,0,0,1,1, 0,0,0,0,0,0, 10,0));
        vecs.push_back(mk(0,0,0,1,0,1, 0,0,0,0,0,0, 10,0));
        vecs.push_back(mk(0,0,0,1,0,1, 0,0,0,0,0,0, 10,1));
        vecs.push_back(mk(0,0,0,1,0,1, 0,0,0,0,0,0, 10,1));
        vecs.push_back(mk(0,0,0,1,1,1, 1,0,0,0,0,0, 10,1));
        vecs.push_back(mk(0,0,0,1,0,1, 1,0,0,0,0,1, 8,1));
        vecs.push_back(mk(0,0,0,1,0,1, 1,0,0,1,0,1, 8,1));
        vecs.push_back(mk(0,0,0,1,0,1, 1,0,0,0,0,1, 8,0));
        vecs.push_back(mk(0,0,0,1,0,1, 0,0,0,0,0,0, 8,0));
        vecs.push_back(mk(0,0,0,9,0,1, 0,0,0,0,0,0, 8,0));
        vecs.push_back(mk(0,0,1,9,1,1, 1,0,0,0,0,0, 8,8));
        vecs.push_back(mk(0,0,0,9,1,1, 1,0,0,0,0,1, 11,8));
        vecs.push_back(mk(0,0,0,9,1,1, 1,0,0,1,0,1, 11,8));
        vecs.push_back(mk(0,0,0,9,1,1, 1,0,0,0,0,1, 11,0));
        vecs.push_back(mk(0,0,0,9,1,1, 0,0,0,0,0,0, 11,0));
        vecs.push_back(mk(0,0,1,0,0,1, 1,0,0,0,0,0, 11,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0,1, 1,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,0,0,0,1,1, 1,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,0,0,0,0,1, 1,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 1,0));

        foreach (vecs[k]) begin
            step();
            drive(vecs[k].ill, vecs[k].trap, vecs[k].rfi, vecs[k].irq, vecs[k].ie, vecs[k].idle);
            #1;
            check($sformatf("v%0d_flush", k), 32'(bus_if.flush), 32'(vecs[k].e_flush));
            check($sformatf("v%0d_ill", k), 32'(bus_if.ill_inst), 32'(vecs[k].e_ill));
            check($sformatf("v%0d_trap", k), 32'(bus_if.trap), 32'(vecs[k].e_trap));
            check($sformatf("v%0d_take", k), 32'(bus_if.irq_take), 32'(vecs[k].e_take));
            check($sformatf("v%0d_rfi", k), 32'(bus_if.rfi), 32'(vecs[k].e_rfi));
            check($sformatf("v%0d_busy", k), 32'(bus_if.busy), 32'(vecs[k].e_busy));
            check($sformatf("v%0d_cause", k), 32'(bus_if.cause), 32'(vecs[k].e_cause));
            check($sformatf("v%0d_pend", k), 32'(bus_if.pending), 32'(vecs[k].e_pend));
        end

        // Drain timeout: pipe_idle held low, strobe after DRAIN_MAX+1 drain cycles
        step();
        drive(0, 1, 0, 4'h0, 0, 0);
        #1;
        check("to_sel_flush", 32'(bus_if.flush), 1);
        step();
        drive(0, 0, 0, 4'h0, 0, 0);
        first_idx = -1;
        n_ill = 0; n_trap = 0; n_take = 0; n_rfi = 0;
        cause_at = 4'h0;
        for (int n = 0; n < 40; n++) begin
            if (bus_if.trap && first_idx < 0) begin
                first_idx = n;
                cause_at  = bus_if.cause;
            end
            n_ill  += int'(bus_if.ill_inst);
            n_trap += int'(bus_if.trap);
            n_take += int'(bus_if.irq_take);
            n_rfi  += int'(bus_if.rfi);
            step();
        end
        check("to_drain_len", 32'(first_idx), 16);
        check("to_cause", 32'(cause_at), 5);
        check("to_trap_cnt", 32'(n_trap), 1);
        check("to_other_cnt", 32'(n_ill + n_take + n_rfi), 0);
        check("to_idle_busy", 32'(bus_if.busy), 0);

        // Asynchronous reset mid-DRAIN with an interrupt pending
        drive(0, 0, 0, 4'h1, 0, 0);
        step();
        drive(0, 0, 0, 4'h0, 0, 0);
        step();
        check("ar_pend_pre", 32'(bus_if.pending), 1);
        drive(1, 0, 0, 4'h0, 0, 0);
        step();
        drive(0, 0, 0, 4'h0, 0, 0);
        step();
        step();
        check("ar_busy_pre", 32'(bus_if.busy), 1);
        #2 rst = 1'b1;
        #1;
        check("ar_flush", 32'(bus_if.flush), 0);
        check("ar_busy", 32'(bus_if.busy), 0);
        check("ar_strobes", 32'({bus_if.ill_inst, bus_if.trap, bus_if.irq_take, bus_if.rfi}), 0);
        check("ar_cause", 32'(bus_if.cause), 0);
        check("ar_pending", 32'(bus_if.pending), 0);
        #2 rst = 1'b0;
        n_ill = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            n_ill += int'(bus_if.ill_inst) + int'(bus_if.trap) + int'(bus_if.irq_take) + int'(bus_if.rfi);
        end
        check("ar_no_strobe", 32'(n_ill), 0);
        check("ar_pend_post", 32'(bus_if.pending), 0);
        check("ar_busy_post", 32'(bus_if.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
